// File: rtl/ctl_cmd_sequencer.sv
// ctl_cmd_sequencer
//
// Command sequencer feeding the `controller` block. Commands ({mode, count})
// are queued in a small FIFO. Load commands (mode[3:0] == 4'h2) serialise a
// 32-bit payload stream one bit per cycle. Every other mode is held for
// `count` cycles.
//
// Optional build macro: CTL_SEQ_GAP_EN
//   When defined, one idle (mode 0) GAP cycle separates consecutive commands,
//   and `done` pulses in that cycle. When undefined, commands run back-to-back.
//
// Ports
//   clk, reset      clock, asynchronous active-low reset
//   enable          global run; low freezes all state
//   cmd_valid/ready command FIFO write handshake (cmd_mode, cmd_count)
//   bit_valid/ready payload word handshake (bit_word, LSB first)
//   ctl_enable      registered copy of enable
//   ctl_mode        mode word driven to controller (0 when idle or stalled)
//   ctl_in_data     serial payload bit, always 0 or 1
//   busy            FSM active or commands pending
//   done            one-cycle pulse per completed command
//
// FSM states
//   state  | meaning
//   IDLE   | no command active; pops FIFO head when present
//   LOAD   | serialising payload bits, stalls when no bit is available
//   RUN    | holding mode for the programmed number of cycles
//   GAP    | one mode-0 cycle between commands (CTL_SEQ_GAP_EN builds only)

module ctl_cmd_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [31:0]        cmd_mode,
    input  logic [CNT_W-1:0]   cmd_count,
    input  logic               bit_valid,
    output logic               bit_ready,
    input  logic [31:0]        bit_word,
    output logic               ctl_enable,
    output logic [31:0]        ctl_mode,
    output logic signed [31:0] ctl_in_data,
    output logic               busy,
    output logic               done
);

    localparam int          AW        = $clog2(CMD_DEPTH);
    localparam logic [AW:0] FIFO_FULL = (AW+1)'(CMD_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Command FIFO
    logic [31:0]      fifo_mode  [CMD_DEPTH];
    logic [CNT_W-1:0] fifo_count [CMD_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fifo_used;
    logic [AW:0]      fifo_used_nxt;
    logic             fifo_empty;
    logic             fifo_full;
    logic [31:0]      head_mode;
    logic [CNT_W-1:0] head_count;
    logic             head_zero;

    // Active command and payload
    logic [31:0]      mode_r;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      shreg;
    logic [5:0]       bits_left;
    logic             fin;

    logic push;
    logic pop;
    logic in_load;
    logic load_emit;
    logic emit;
    logic emit_bit;
    logic finishing;
    logic bit_take;

    assign fifo_empty = (fifo_used == '0);
    assign fifo_full  = (fifo_used == FIFO_FULL);
    assign head_mode  = fifo_mode[rd_ptr];
    assign head_count = fifo_count[rd_ptr];
    assign head_zero  = (head_count == '0);

    // Both ready signals are gated by reset so they read 0 while reset is held.
    assign cmd_ready = reset & enable & ~fifo_full;
    assign push      = cmd_valid & cmd_ready;

    assign in_load   = (state == S_LOAD);
    // A LOAD cycle is active when a bit is buffered or a fresh word arrives now.
    assign load_emit = in_load & ((bits_left != 6'd0) | bit_valid);
    assign emit      = load_emit | (state == S_RUN);
    assign finishing = emit & (cnt == CNT_W'(1));
    assign emit_bit  = (bits_left != 6'd0) ? shreg[0] : bit_word[0];

    // In LOAD the last buffered bit is always consumed, so a new word can be
    // taken in the same cycle for gap-free streaming. Elsewhere only preload
    // into an empty register.
    assign bit_ready = reset & enable &
                       ((bits_left == 6'd0) | (in_load & (bits_left == 6'd1)));
    assign bit_take  = bit_valid & bit_ready;

`ifdef CTL_SEQ_GAP_EN
    assign pop = enable & ~fifo_empty & ((state == S_IDLE) | (state == S_GAP));
`else
    // Back-to-back: the next head is popped on the final active cycle. A
    // zero-count head is left for IDLE to discard.
    assign pop = enable & ~fifo_empty & ((state == S_IDLE) | (finishing & ~head_zero));
`endif

    always_comb begin
        state_nxt = state;
        if (finishing) begin
`ifdef CTL_SEQ_GAP_EN
            state_nxt = fifo_empty ? S_IDLE : S_GAP;
`else
            state_nxt = S_IDLE;
`endif
        end else if (state == S_GAP) begin
            state_nxt = S_IDLE;
        end
        if (pop) begin
            if (head_zero) begin
                state_nxt = S_IDLE;
            end else if (head_mode[3:0] == 4'h2) begin
                state_nxt = S_LOAD;
            end else begin
                state_nxt = S_RUN;
            end
        end
    end

    always_comb begin
        fifo_used_nxt = fifo_used;
        if (push & ~pop) begin
            fifo_used_nxt = fifo_used + (AW+1)'(1);
        end else if (pop & ~push) begin
            fifo_used_nxt = fifo_used - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mode[wr_ptr]  <= cmd_mode;
            fifo_count[wr_ptr] <= cmd_count;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_used <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_used <= fifo_used_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            mode_r      <= '0;
            cnt         <= '0;
            shreg       <= '0;
            bits_left   <= '0;
            fin         <= 1'b0;
            ctl_enable  <= 1'b0;
            ctl_mode    <= '0;
            ctl_in_data <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            ctl_enable <= enable;
            if (!enable) begin
                ctl_mode    <= '0;
                ctl_in_data <= '0;
                done        <= 1'b0;
            end else begin
                state <= state_nxt;
                busy  <= (state_nxt != S_IDLE) | (fifo_used_nxt != '0);
                // fin marks the final active cycle; done follows one cycle later.
                fin   <= finishing;
                done  <= fin | (pop & head_zero);

                ctl_mode    <= emit ? mode_r : 32'h0;
                ctl_in_data <= (load_emit & emit_bit) ? 32'sd1 : 32'sd0;

                if (emit) begin
                    cnt <= cnt - CNT_W'(1);
                end
                if (pop) begin
                    cnt    <= head_count;
                    mode_r <= head_mode;
                end

                if (load_emit & (bits_left != 6'd0)) begin
                    shreg     <= {1'b0, shreg[31:1]};
                    bits_left <= bits_left - 6'd1;
                end
                if (bit_take) begin
                    if (in_load & (bits_left == 6'd0)) begin
                        // bit 0 goes straight out this cycle
                        shreg     <= {1'b0, bit_word[31:1]};
                        bits_left <= 6'd31;
                    end else begin
                        shreg     <= bit_word;
                        bits_left <= 6'd32;
                    end
                end
                // A load that ends mid-word drops the leftover bits. A complete
                // word taken on the final cycle is kept for the next command.
                if (finishing & in_load & ~(bit_take & (bits_left != 6'd0))) begin
                    bits_left <= '0;
                end
            end
        end
    end

endmodule
